// File: rtl/repl_pkg.sv
// repl_pkg: shared policy and FSM types for the victim-selection block
package repl_pkg;
    typedef enum logic {REPL_PLRU, REPL_RR} repl_mode_e;
    typedef enum logic {INIT, IDLE} state_e;
endpackage

// File: rtl/plru_repl_if.sv
// plru_repl_if: flush/request/response/update bundle between a cache controller and plru_repl
interface plru_repl_if #(parameter int INDEX_BITS = 6, parameter int NUM_WAYS = 4, parameter int WAY_BITS = 2);
    logic flush, busy;
    logic req_valid, req_ready;
    logic [INDEX_BITS-1:0] req_index;
    logic [NUM_WAYS-1:0] valid_mask, lock_mask;
    logic rsp_valid, rsp_all_locked;
    logic [WAY_BITS-1:0] rsp_way;
    logic upd_valid;
    logic [INDEX_BITS-1:0] upd_index;
    logic [WAY_BITS-1:0] upd_way;
    modport master (
        output flush, req_valid, req_index, valid_mask, lock_mask, upd_valid, upd_index, upd_way,
        input busy, req_ready, rsp_valid, rsp_way, rsp_all_locked
    );
    modport slave (
        input flush, req_valid, req_index, valid_mask, lock_mask, upd_valid, upd_index, upd_way,
        output busy, req_ready, rsp_valid, rsp_way, rsp_all_locked
    );
endinterface

// File: rtl/plru_tree_select.sv
// plru_tree_select: walks a pseudo-LRU tree from the root, steering around fully locked subtrees
module plru_tree_select #(
    parameter int NUM_WAYS = 4,
    localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] tree,
    input  logic [NUM_WAYS-1:0] lock_mask,
    output logic [WAY_BITS-1:0] way,
    output logic                all_locked
);
    logic [NUM_WAYS-1:0] avail, lo_m, hi_m;
    logic [WAY_BITS-1:0] base, node;
    logic go;
    always_comb begin
        avail = ~lock_mask;
        base = '0;
        node = '0;
        go = 1'b0;
        lo_m = '0;
        hi_m = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            lo_m = NUM_WAYS'((1 << (NUM_WAYS >> (l + 1))) - 1) << base;
            hi_m = lo_m << (NUM_WAYS >> (l + 1));
            go = tree[node] ? |(avail & hi_m) : !(|(avail & lo_m));
            base = base + (go ? WAY_BITS'(NUM_WAYS >> (l + 1)) : '0);
            node = node + node + WAY_BITS'(1) + WAY_BITS'(go);
        end
        all_locked = !(|avail);
        way = all_locked ? '0 : base;
    end
endmodule

// File: rtl/plru_repl.sv
// plru_repl: per-set victim selection (tree PLRU or round-robin) with invalid-first and lock masking
module plru_repl
    import repl_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 4,
    parameter repl_mode_e MODE = REPL_PLRU,
    localparam int INDEX_BITS = $clog2(NUM_SETS),
    localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
    input logic clk,
    input logic rst,
    plru_repl_if.slave bus
);
    localparam int TW = NUM_WAYS - 1;
    localparam int SW = (MODE == REPL_PLRU) ? TW : WAY_BITS;
    state_e state;
    logic [INDEX_BITS-1:0] walk;
    logic [SW-1:0] rd, wdata, wmask;
    logic [TW-1:0] tree, path_d, path_m;
    logic [WAY_BITS-1:0] tree_way, rr_way, inv_way, victim, node, sh;
    logic tree_locked, inv_hit, accept, upd_en;

    assign accept = bus.req_valid && bus.req_ready;
    assign upd_en = bus.upd_valid && state == IDLE;
    assign bus.busy = state == INIT;
    assign bus.req_ready = state == IDLE;
    assign tree = TW'(rd);

    // Bit-sliced storage: one read port, one write port with per-bit enable, no read-modify-write
    for (genvar b = 0; b < SW; b++) begin : g_bit
        logic bits [NUM_SETS];
        assign rd[b] = bits[bus.req_index];
        always_ff @(posedge clk)
            if (state == INIT) bits[walk] <= 1'b0;
            else if (upd_en && wmask[b]) bits[bus.upd_index] <= wdata[b];
    end

    plru_tree_select #(.NUM_WAYS(NUM_WAYS)) u_sel (
        .tree(tree),
        .lock_mask(bus.lock_mask),
        .way(tree_way),
        .all_locked(tree_locked)
    );

    always_comb begin
        inv_hit = 1'b0;
        inv_way = '0;
        rr_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!bus.valid_mask[WAY_BITS'(w)] && !bus.lock_mask[WAY_BITS'(w)]) begin
                inv_hit = 1'b1;
                inv_way = WAY_BITS'(w);
            end
            if (!bus.lock_mask[WAY_BITS'(rd) + WAY_BITS'(w)]) rr_way = WAY_BITS'(rd) + WAY_BITS'(w);
        end
        victim = tree_locked ? '0 : inv_hit ? inv_way : (MODE == REPL_PLRU) ? tree_way : rr_way;
    end

    always_comb begin
        path_d = '0;
        path_m = '0;
        node = '0;
        sh = bus.upd_way;
        for (int l = 0; l < WAY_BITS; l++) begin
            path_m[node] = 1'b1;
            path_d[node] = !sh[WAY_BITS-1];
            node = node + node + WAY_BITS'(1) + WAY_BITS'(sh[WAY_BITS-1]);
            sh = sh << 1;
        end
        wdata = (MODE == REPL_PLRU) ? SW'(path_d) : SW'(bus.upd_way + WAY_BITS'(1));
        wmask = (MODE == REPL_PLRU) ? SW'(path_m) : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            walk <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_way <= '0;
            bus.rsp_all_locked <= 1'b0;
        end else begin
            state <= bus.flush ? INIT : (state == INIT && walk == INDEX_BITS'(NUM_SETS - 1)) ? IDLE : state;
            walk <= (bus.flush || state == IDLE) ? '0 : walk + INDEX_BITS'(1);
            bus.rsp_valid <= accept;
            bus.rsp_way <= accept ? victim : bus.rsp_way;
            bus.rsp_all_locked <= accept ? tree_locked : bus.rsp_all_locked;
        end
    end
endmodule

// File: doc/plru_repl.md
PLRU_REPL -- requirements
Module: plru_repl

Interface
REQ-001 Parameter NUM_SETS, default 64, number of sets; SHALL be a power of 2 and at least 2.
REQ-002 Parameter NUM_WAYS, default 4, associativity; SHALL be a power of 2 and at least 2.
REQ-003 Parameter MODE, default REPL_PLRU, policy select: REPL_PLRU (tree pseudo-LRU) or REPL_RR (per-set round-robin pointer).
REQ-004 Derived parameters: INDEX_BITS = $clog2(NUM_SETS), WAY_BITS = $clog2(NUM_WAYS).
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  pulse; requests re-initialisation of all replacement state.
REQ-008 busy  out  1  high while the block is initialising.
REQ-009 req_valid  in  1  victim request.
REQ-010 req_ready  out  1  request acceptance; equals !busy.
REQ-011 req_index  in  INDEX_BITS  set to query.
REQ-012 valid_mask  in  NUM_WAYS  per-way line-valid bits of req_index.
REQ-013 lock_mask  in  NUM_WAYS  per-way lock bits; a locked way SHALL never be chosen.
REQ-014 rsp_valid  out  1  one-cycle pulse; victim result is valid.
REQ-015 rsp_way  out  WAY_BITS  chosen victim way.
REQ-016 rsp_all_locked  out  1  no eligible way exists.
REQ-017 upd_valid  in  1  access (hit or fill) notification.
REQ-018 upd_index  in  INDEX_BITS  set accessed.
REQ-019 upd_way  in  WAY_BITS  way accessed.

Function
REQ-020 Per-set state SHALL be NUM_WAYS-1 tree bits (REPL_PLRU) or a WAY_BITS pointer (REPL_RR).
REQ-021 FSM states SHALL be INIT and IDLE. INIT clears one set per cycle, indices 0 to NUM_SETS-1, then moves to IDLE; INIT therefore lasts exactly NUM_SETS cycles.
REQ-022 flush in IDLE SHALL enter INIT starting at index 0; flush in INIT SHALL restart the walk at index 0.
REQ-023 A request is accepted when req_valid && req_ready. rsp_valid SHALL be high exactly one cycle later, with rsp_way and rsp_all_locked registered.
REQ-024 Victim priority 1: the lowest-index way with valid_mask=0 and lock_mask=0.
REQ-025 Victim priority 2, REPL_PLRU: walk the tree from the root. Node bit 0 selects the lower-index half, 1 the upper half. If the chosen subtree is fully locked, take the other subtree.
REQ-026 Victim priority 2, REPL_RR: the first unlocked way at or after the pointer, searching upward modulo NUM_WAYS.
REQ-027 If all ways are locked, rsp_all_locked=1 and rsp_way=0.
REQ-028 Victim selection SHALL NOT modify state.
REQ-029 Accepted update, REPL_PLRU: every node on the path to upd_way is set to point away from it (1 if upd_way is in the lower half, else 0).
REQ-030 Accepted update, REPL_RR: pointer <= (upd_way+1) mod NUM_WAYS; wrap from NUM_WAYS-1 to 0.
REQ-031 upd_valid SHALL be ignored while busy.
REQ-032 A request and an update to the same index in the same cycle: the victim SHALL be computed from the pre-update state, and the update SHALL still take effect.
REQ-033 Updates to different sets SHALL never disturb each other.

Reset
REQ-034 While rst is high: FSM=INIT, walk index=0, rsp_valid=0, rsp_way=0, rsp_all_locked=0, busy=1, req_ready=0.
REQ-035 After rst deasserts, busy SHALL stay high for NUM_SETS cycles, then all set states SHALL be zero.
REQ-036 rst asserted mid-INIT or mid-response SHALL abort the operation; no rsp_valid SHALL follow.

Structure
REQ-037 Package repl_pkg SHALL hold the repl_mode_e enum (REPL_PLRU, REPL_RR) and the FSM state typedef.
REQ-038 Combinational sub-module plru_tree_select SHALL take tree bits and lock_mask and return the victim way and an all-locked flag.
REQ-039 Set state SHALL be a flat register array with one read port and one write port, suitable for later replacement by SRAM.

Verification
REQ-040 Reset, 4 ways, 64 sets: busy is high for 64 cycles; then a request to set 5 with valid_mask=4'b1111 and lock_mask=0 gives rsp_way=0 one cycle after acceptance.
REQ-041 PLRU: update way 0 of set 3, then request with all lines valid -> rsp_way=2; then update way 2 -> rsp_way=1.
REQ-042 Invalid preference: valid_mask=4'b1011, lock_mask=0 -> rsp_way=2 regardless of tree state; with lock_mask=4'b0100 -> the tree result, never 2.
REQ-043 Locks: lock_mask=4'b1111 -> rsp_all_locked=1, rsp_way=0; tree points to way 2 and lock_mask=4'b1100 -> rsp_way=0.
REQ-044 REPL_RR: update way 3 of set 7 -> pointer wraps and rsp_way=0; a same-cycle request and update to set 7 returns the pre-update victim.
REQ-045 Flush while IDLE with nonzero state: busy for 64 cycles, then every set returns rsp_way=0; upd_valid pulses during INIT have no effect.
